// File: rtl/uart_program_loader_pkg.sv
// Shared types for the UART program loader: FSM states, byte-lane index and
// the partial-word byte-enable helper.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } loader_state_t;

  typedef logic [1:0] lane_t;

  // Byte enables covering the first n lanes of a partially assembled word.
  function automatic logic [3:0] lane_be(input lane_t n);
    logic [3:0] be;
    case (n)
      2'd1:    be = 4'b0001;
      2'd2:    be = 4'b0011;
      2'd3:    be = 4'b0111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Byte stream from the UART receiver plus the instruction-RAM write port.
// master = loader side, slave = receiver/RAM side.
interface uart_program_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/uart_program_loader.sv
// Packs received UART bytes little-endian into instruction-RAM words and holds
// the core in reset until the image is loaded. LOADER_TIMEOUT_EN closes short images.
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned PROG_BYTES     = 4096,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                        clock,
  input  logic                        rst_n,
  uart_program_loader_if.master       bus,
  input  logic                        reload,
  output logic                        cpu_rst_n,
  output logic                        program_receiving,
  output logic                        program_done,
  output logic                        program_ov,
  output logic [$clog2(PROG_BYTES):0] byte_count
);

  localparam int unsigned CNT_W = $clog2(PROG_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PROG_BYTES - 1);

  if ((PROG_BYTES % 4) != 0 || PROG_BYTES == 0 ||
      ((2 ** ADDR_W) * 4) < PROG_BYTES || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("uart_program_loader: illegal parameter combination");
  end

  loader_state_t     state;
  lane_t             lane;
  logic [3:0][7:0]   asm_q;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              we_q;
  logic              timeout_hit;

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] idle_cnt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (reload || bus.rx_valid || state != LOAD) begin
      idle_cnt <= '0;
    end else if (!timeout_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == LOAD) && (idle_cnt == TMR_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      lane              <= '0;
      asm_q             <= '0;
      word_addr         <= '0;
      we_q              <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      be_q              <= '0;
      cpu_rst_n         <= 1'b0;
      program_receiving <= 1'b0;
      program_done      <= 1'b0;
      program_ov        <= 1'b0;
      byte_count        <= '0;
    end else begin
      we_q              <= 1'b0;
      be_q              <= '0;
      program_receiving <= 1'b0;
      // Status follows the registered state, so it rises the cycle after the final write.
      program_done      <= (state == DONE) && !reload;
      cpu_rst_n         <= (state == DONE) && !reload;
      if (reload) begin
        state      <= IDLE;
        lane       <= '0;
        asm_q      <= '0;
        word_addr  <= '0;
        byte_count <= '0;
        program_ov <= 1'b0;
      end else begin
        case (state)
          IDLE, LOAD: begin
            if (bus.rx_valid) begin
              program_receiving <= 1'b1;
              byte_count        <= byte_count + 1'b1;
              lane              <= lane + 1'b1;
              if (lane == 2'd3) begin
                we_q    <= 1'b1;
                be_q    <= '1;
                wdata_q <= {bus.rx_data, asm_q[2], asm_q[1], asm_q[0]};
                addr_q  <= word_addr;
                if (word_addr != '1) word_addr <= word_addr + 1'b1;
                asm_q   <= '0;
              end else begin
                asm_q[lane] <= bus.rx_data;
              end
              state <= (byte_count == LAST_BYTE) ? DONE : LOAD;
            end else if (timeout_hit) begin
              state <= FLUSH;
            end
          end
          FLUSH: begin
            if (lane != '0) begin
              we_q    <= 1'b1;
              be_q    <= lane_be(lane);
              wdata_q <= asm_q;
              addr_q  <= word_addr;
            end
            lane  <= '0;
            asm_q <= '0;
            state <= DONE;
          end
          DONE: begin
            if (bus.rx_valid) program_ov <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: a byte-level reference model queues
// expected RAM writes and byte counts; a negedge monitor pops and compares them.
module tb_uart_program_loader;

  localparam int unsigned PROG_BYTES = 4096;
  localparam int unsigned ADDR_W     = 10;
`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = 50;
`else
  localparam int unsigned TIMEOUT_CYCLES = 1000000;
`endif
  localparam int unsigned CNT_W = $clog2(PROG_BYTES) + 1;

  logic             clock  = 1'b0;
  logic             rst_n  = 1'b1;
  logic             reload = 1'b0;
  logic             cpu_rst_n;
  logic             program_receiving;
  logic             program_done;
  logic             program_ov;
  logic [CNT_W-1:0] byte_count;

  uart_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_program_loader #(
    .PROG_BYTES    (PROG_BYTES),
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .bus              (bus),
    .reload           (reload),
    .cpu_rst_n        (cpu_rst_n),
    .program_receiving(program_receiving),
    .program_done     (program_done),
    .program_ov       (program_ov),
    .byte_count       (byte_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  wr_t         wq[$];
  int unsigned rq[$];

  int unsigned m_n;
  int unsigned m_word;
  logic [7:0]  m_buf[$];
  bit          m_done;
  bit          m_ov;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_n    = 0;
    m_word = 0;
    m_buf.delete();
    m_done = 1'b0;
    m_ov   = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    wr_t w;
    if (m_done) begin
      m_ov = 1'b1;
      return;
    end
    m_buf.push_back(b);
    m_n++;
    rq.push_back(m_n);
    if (m_buf.size() == 4) begin
      w.addr = ADDR_W'(m_word);
      w.data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
      w.be   = 4'hF;
      wq.push_back(w);
      m_word++;
      m_buf.delete();
    end
    if (m_n == PROG_BYTES) m_done = 1'b1;
  endfunction

`ifdef LOADER_TIMEOUT_EN
  function automatic void model_flush();
    wr_t w;
    w.addr = ADDR_W'(m_word);
    w.data = '0;
    for (int i = 0; i < m_buf.size(); i++) w.data = w.data | (32'(m_buf[i]) << (8 * i));
    w.be = 4'((1 << m_buf.size()) - 1);
    if (m_buf.size() > 0) wq.push_back(w);
    m_buf.delete();
    m_done = 1'b1;
  endfunction
`endif

  task automatic drive(input logic v, input logic [7:0] d, input logic rel);
    @(posedge clock);
    #1;
    bus.rx_valid = v;
    bus.rx_data  = d;
    reload       = rel;
    if (rel) model_clear();
    else if (v) model_byte(d);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clock) begin : monitor
    wr_t w;
    if (rst_n) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) begin
          check("write_when_none_expected", 64'(bus.mem_we), 64'd0);
        end else begin
          w = wq.pop_front();
          check("ram_write", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'(w));
        end
      end
      if (program_receiving) begin
        if (rq.size() == 0) check("receiving_when_none_expected", 64'(program_receiving), 64'd0);
        else check("receiving_byte_count", 64'(byte_count), 64'(rq.pop_front()));
      end
    end
  end

  initial begin : stimulus
    logic [7:0] first4 [4];
    int unsigned k;
    first4 = '{8'h13, 8'h05, 8'h00, 8'h00};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_clear();
    #1 rst_n = 1'b0;
    #11;
    check("reset_bus", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'd0);
    check("reset_status", 64'({cpu_rst_n, program_receiving, program_done, program_ov, byte_count}), 64'd0);
    @(negedge clock);
    rst_n = 1'b1;

    // Known first word, then the rest of a full image at one byte per cycle.
    foreach (first4[i]) drive(1'b1, first4[i], 1'b0);
    for (int unsigned i = 4; i < PROG_BYTES; i++) drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("last_write_strobe", 64'(bus.mem_we), 64'd1);
    check("done_low_during_last_write", 64'(program_done), 64'd0);
    @(negedge clock);
    check("done_after_full_image", 64'(program_done), 64'(m_done));
    check("cpu_released", 64'(cpu_rst_n), 64'd1);
    check("full_byte_count", 64'(byte_count), 64'(PROG_BYTES));

    // Bytes after done only raise the sticky overflow flag.
    drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("overflow_set", 64'(program_ov), 64'(m_ov));
    idle(5);
    @(negedge clock);
    check("overflow_sticky", 64'(program_ov), 64'd1);
    check("count_held_after_done", 64'(byte_count), 64'(PROG_BYTES));

    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("reload_status", 64'({program_done, program_ov, cpu_rst_n}), 64'd0);
    check("reload_count", 64'(byte_count), 64'd0);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'($urandom), 1'b0);
    end
    drive(1'b1, 8'($urandom), 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("reload_midload_count", 64'(byte_count), 64'd0);

    for (int unsigned i = 0; i < PROG_BYTES; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'($urandom), 1'b0);
    end
    idle(2);
    @(negedge clock);
    check("done_after_gappy_image", 64'(program_done), 64'd1);

    // Asynchronous reset in the middle of a word.
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_bus", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'd0);
    check("async_reset_status", 64'({cpu_rst_n, program_receiving, program_done, program_ov, byte_count}), 64'd0);
    model_clear();
    @(negedge clock);
    rst_n = 1'b1;

    // Short image: six bytes then silence.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
`ifdef LOADER_TIMEOUT_EN
    model_flush();
    k = 0;
    while (!program_done && k < 4 * TIMEOUT_CYCLES) begin
      @(negedge clock);
      k++;
    end
    check("timeout_done", 64'(program_done), 64'd1);
    check("timeout_not_early", 64'(k >= TIMEOUT_CYCLES), 64'd1);
    check("timeout_cpu_released", 64'(cpu_rst_n), 64'd1);
`else
    k = 0;
    idle(100);
    @(negedge clock);
    check("short_image_not_done", 64'({program_done, cpu_rst_n}), 64'd0);
    check("short_image_count", 64'(byte_count), 64'(m_n + k));
`endif

    idle(3);
    @(negedge clock);
    check("writes_outstanding", 64'(wq.size()), 64'd0);
    check("receiving_outstanding", 64'(rq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
